// File: rtl/snn_noc_pkg.sv
// Shared packet layout, type codes and FSM states for the SNN NoC memory packetizer.
package snn_noc_pkg;
    localparam int ADDR_W   = 4;
    localparam int TYPE_W   = 2;
    localparam int HDR_W    = 2*ADDR_W + TYPE_W;
    // Field MSB position is NOC_W - *_OFS
    localparam int SRC_OFS  = 1;
    localparam int DST_OFS  = SRC_OFS + ADDR_W;
    localparam int TYPE_OFS = DST_OFS + ADDR_W;
    localparam logic [9:0] DONE_MARK = 10'h1FF;

    typedef enum logic [1:0] {
        PKT_IFM = 2'b00,
        PKT_KRN = 2'b01,
        PKT_OUT = 2'b11
    } pktType_e;

    typedef enum logic [2:0] {
        IDLE, FLT_RD, FLT_SEND, IFM_RD, IFM_SEND, WAIT_DONE, FINISH
    } pkzState_e;
endpackage

// File: rtl/noc_mem_packetizer_if.sv
// Control, memory and NoC packet signals of the packetizer; master = packetizer side.
interface noc_mem_packetizer_if #(
    parameter int NOC_W    = 64,
    parameter int WEIGHT_W = 8
);
    localparam int RDW = (WEIGHT_W > 1) ? WEIGHT_W : 1;

    logic             start, busy, done, err;
    logic             mem_rd_en, mem_rd_sel;
    logic [7:0]       mem_t, mem_row, mem_col;
    logic [RDW-1:0]   mem_rd_data;
    logic             mem_wr_en;
    logic [7:0]       mem_wr_t, mem_wr_row, mem_wr_col;
    logic             flt_valid, flt_ready;
    logic [NOC_W-1:0] flt_data;
    logic             ifm_valid, ifm_ready;
    logic [NOC_W-1:0] ifm_data;
    logic             ofm_valid, ofm_ready;
    logic [NOC_W-1:0] ofm_data;

    modport master (
        input  start, mem_rd_data, flt_ready, ifm_ready, ofm_valid, ofm_data,
        output busy, done, err, mem_rd_en, mem_rd_sel, mem_t, mem_row, mem_col,
               mem_wr_en, mem_wr_t, mem_wr_row, mem_wr_col,
               flt_valid, flt_data, ifm_valid, ifm_data, ofm_ready
    );

    modport slave (
        output start, mem_rd_data, flt_ready, ifm_ready, ofm_valid, ofm_data,
        input  busy, done, err, mem_rd_en, mem_rd_sel, mem_t, mem_row, mem_col,
               mem_wr_en, mem_wr_t, mem_wr_row, mem_wr_col,
               flt_valid, flt_data, ifm_valid, ifm_data, ofm_ready
    );
endinterface

// File: rtl/row_packer.sv
// Collects one memory row into a payload word: filter rows as WEIGHT_W fields, ifmap rows as bits.
module row_packer #(
    parameter int WEIGHT_W  = 8,
    parameter int FILT_COLS = 5,
    parameter int IFM_COLS  = 25,
    parameter int PW        = 40,
    parameter int RDW       = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sel,
    input  logic          rdEn,
    input  logic [RDW-1:0] rdData,
    output logic [7:0]    col,
    output logic          full,
    output logic [PW-1:0] payload
);
    logic       rdVld;
    logic [7:0] insCol;
    logic [7:0] lastCol;

    assign lastCol = sel ? 8'(IFM_COLS - 1) : 8'(FILT_COLS - 1);

    // Read data lands one cycle after the read, so the insert column trails col by one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col     <= '0;
            rdVld   <= 1'b0;
            insCol  <= '0;
            full    <= 1'b0;
            payload <= '0;
        end else begin
            rdVld  <= rdEn;
            insCol <= col;
            if (rdEn) col <= col + 8'd1;
            if (rdVld) begin
                if (sel) begin
                    for (int i = 0; i < IFM_COLS; i++)
                        if (insCol == 8'(i)) payload[i] <= rdData[0];
                end else begin
                    for (int i = 0; i < FILT_COLS; i++)
                        if (insCol == 8'(i)) payload[i*WEIGHT_W +: WEIGHT_W] <= rdData[WEIGHT_W-1:0];
                end
                if (insCol == lastCol) full <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/noc_mem_packetizer.sv
// Streams filter and ifmap rows from memory as NoC packets and writes returning output spikes back.
module noc_mem_packetizer
    import snn_noc_pkg::*;
#(
    parameter int NUM_PE      = 5,
    parameter int FILT_ROWS   = 5,
    parameter int FILT_COLS   = 5,
    parameter int WEIGHT_W    = 8,
    parameter int IFM_ROWS    = 25,
    parameter int IFM_COLS    = 25,
    parameter int OFM_ROWS    = 21,
    parameter int OFM_COLS    = 21,
    parameter int TIMESTEPS   = 10,
    parameter int NOC_W       = 64,
    parameter int DONES_PER_T = 7,
    parameter bit RELOAD_FILT = 1'b0,
    parameter logic [3:0] SRC_ADDR = 4'h0,
    parameter logic [NUM_PE*4-1:0] PE_ADDR = {4'h9, 4'h3, 4'h2, 4'h1, 4'h0}
)(
    input logic clk,
    input logic rst,
    noc_mem_packetizer_if.master bus
);
    localparam int FLT_PW = FILT_COLS * WEIGHT_W;
    localparam int PW     = (FLT_PW > IFM_COLS) ? FLT_PW : IFM_COLS;
    localparam int RDW    = (WEIGHT_W > 1) ? WEIGHT_W : 1;
    localparam logic [7:0] FLT_N  = 8'(FILT_COLS);
    localparam logic [7:0] IFM_N  = 8'(IFM_COLS);
    localparam logic [7:0] DONE_N = 8'(DONES_PER_T);
    localparam logic [7:0] T_LAST = 8'(TIMESTEPS - 1);

    if (PW > NOC_W - HDR_W) begin : gPayloadTooWide
        $error("noc_mem_packetizer: row payload does not fit in NOC_W");
    end

    pkzState_e state, stateNxt;
    logic [7:0] r, t, doneCnt, col, rMod;
    logic [PW-1:0] payload;
    logic [NOC_W-1:0] pkt;
    logic [ADDR_W-1:0] dest;
    logic full, sel, rdEn, clr, tAdvance, rowLast, fltValid, ifmValid, active;
    logic ofmAcc, ofmOut, ofmDone, ofmInRange;
    logic wrEn, err;
    logic [7:0] wrT, wrRow, wrCol;

    row_packer #(
        .WEIGHT_W(WEIGHT_W), .FILT_COLS(FILT_COLS), .IFM_COLS(IFM_COLS), .PW(PW), .RDW(RDW)
    ) uPacker (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .rdEn(rdEn),
        .rdData(bus.mem_rd_data), .col(col), .full(full), .payload(payload)
    );

    assign sel     = (state == IFM_RD) || (state == IFM_SEND);
    assign active  = (state != IDLE) && (state != FINISH);
    assign rowLast = sel ? (r == 8'(IFM_ROWS - 1)) : (r == 8'(FILT_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        rdEn     = 1'b0;
        clr      = 1'b0;
        tAdvance = 1'b0;
        fltValid = 1'b0;
        ifmValid = 1'b0;
        case (state)
            IDLE:     if (bus.start) stateNxt = FLT_RD;
            FLT_RD: begin
                rdEn = (col < FLT_N);
                if (full) stateNxt = FLT_SEND;
            end
            FLT_SEND: begin
                fltValid = 1'b1;
                if (bus.flt_ready) begin
                    clr      = 1'b1;
                    stateNxt = rowLast ? IFM_RD : FLT_RD;
                end
            end
            IFM_RD: begin
                rdEn = (col < IFM_N);
                if (full) stateNxt = IFM_SEND;
            end
            IFM_SEND: begin
                ifmValid = 1'b1;
                if (bus.ifm_ready) begin
                    clr      = 1'b1;
                    stateNxt = rowLast ? WAIT_DONE : IFM_RD;
                end
            end
            WAIT_DONE: begin
                if (doneCnt >= DONE_N) begin
                    tAdvance = 1'b1;
                    if (t == T_LAST)  stateNxt = FINISH;
                    else if (RELOAD_FILT) stateNxt = FLT_RD;
                    else              stateNxt = IFM_RD;
                end
            end
            FINISH:   stateNxt = FINISH;
            default:  stateNxt = IDLE;
        endcase
    end

    always_comb begin
        rMod = 8'(int'(r) % NUM_PE);
        dest = '0;
        for (int i = 0; i < NUM_PE; i++)
            if (rMod == 8'(i)) dest = PE_ADDR[i*4 +: 4];
        pkt = '0;
        pkt[NOC_W-SRC_OFS  -: ADDR_W] = SRC_ADDR;
        pkt[NOC_W-DST_OFS  -: ADDR_W] = dest;
        pkt[NOC_W-TYPE_OFS -: TYPE_W] = sel ? PKT_IFM : PKT_KRN;
        pkt[PW-1:0] = payload;
    end

    assign ofmAcc     = bus.ofm_valid && active;
    assign ofmOut     = bus.ofm_data[NOC_W-TYPE_OFS -: TYPE_W] == PKT_OUT;
    assign ofmDone    = bus.ofm_data[9:0] == DONE_MARK;
    assign ofmInRange = ({3'b0, bus.ofm_data[9:5]} < 8'(OFM_ROWS)) &&
                        ({3'b0, bus.ofm_data[4:0]} < 8'(OFM_COLS));

    // Early done packets (e.g. during IFM_SEND) stay counted; any surplus carries into the next timestep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            t       <= '0;
            doneCnt <= '0;
            err     <= 1'b0;
            wrEn    <= 1'b0;
            wrT     <= '0;
            wrRow   <= '0;
            wrCol   <= '0;
        end else begin
            if (clr) r <= rowLast ? 8'd0 : r + 8'd1;
            if (tAdvance) t <= t + 8'd1;
            doneCnt <= (tAdvance ? doneCnt - DONE_N : doneCnt) + {7'd0, ofmAcc && ofmOut && ofmDone};
            wrEn    <= ofmAcc && ofmOut && !ofmDone && ofmInRange;
            if (ofmAcc && ofmOut && !ofmDone) begin
                if (ofmInRange) begin
                    wrT   <= t;
                    wrRow <= {3'b0, bus.ofm_data[9:5]};
                    wrCol <= {3'b0, bus.ofm_data[4:0]};
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = active;
    assign bus.done       = (state == FINISH);
    assign bus.err        = err;
    assign bus.mem_rd_en  = rdEn;
    assign bus.mem_rd_sel = sel;
    assign bus.mem_t      = t;
    assign bus.mem_row    = r;
    assign bus.mem_col    = col;
    assign bus.mem_wr_en  = wrEn;
    assign bus.mem_wr_t   = wrT;
    assign bus.mem_wr_row = wrRow;
    assign bus.mem_wr_col = wrCol;
    assign bus.flt_valid  = fltValid;
    assign bus.flt_data   = fltValid ? pkt : '0;
    assign bus.ifm_valid  = ifmValid;
    assign bus.ifm_data   = ifmValid ? pkt : '0;
    assign bus.ofm_ready  = active;
endmodule

// File: tb/tb_noc_mem_packetizer.sv
// Directed bench: memory model plus hand-computed packets and write addresses for the packetizer.
module tb_noc_mem_packetizer;
    localparam int NOC_W = 64;
    localparam int WEIGHT_W = 8;
    localparam logic [63:0] OUT_HDR = 64'h00C0_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int nChk = 0;
    int nFail = 0;
    int fltReads = 0;
    int fltPkts = 0;
    int ifmPkts = 0;
    logic [63:0] ifmLog [0:63];

    noc_mem_packetizer_if #(.NOC_W(NOC_W), .WEIGHT_W(WEIGHT_W)) bus();

    noc_mem_packetizer #(.TIMESTEPS(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fltW(input int rr, input int cc);
        return 8'(rr*5 + cc + 1);
    endfunction

    function automatic logic ifmBit(input int tt, input int rr, input int cc);
        if (rr == 3) return (cc == 0) || (cc == 24);
        return ((rr + cc + tt) % 3) == 0;
    endfunction

    function automatic logic [63:0] ifmPkt(input int tt, input int rr, input logic [3:0] dst);
        logic [63:0] p;
        p = '0;
        p[59:56] = dst;
        for (int c = 0; c < 25; c++) p[c] = ifmBit(tt, rr, c);
        return p;
    endfunction

    // Memory answers one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rd_data <= bus.mem_rd_sel ? {7'd0, ifmBit(int'(bus.mem_t), int'(bus.mem_row), int'(bus.mem_col))}
                                              : fltW(int'(bus.mem_row), int'(bus.mem_col));
    end

    always @(posedge clk) begin
        if (bus.mem_rd_en && !bus.mem_rd_sel) fltReads <= fltReads + 1;
        if (bus.flt_valid && bus.flt_ready) fltPkts <= fltPkts + 1;
        if (bus.ifm_valid && bus.ifm_ready && ifmPkts < 64) begin
            ifmLog[ifmPkts] <= bus.ifm_data;
            ifmPkts <= ifmPkts + 1;
        end
    end

    task automatic sendOfm(input logic [63:0] d);
        bus.ofm_valid = 1'b1;
        bus.ofm_data  = d;
        @(negedge clk);
        bus.ofm_valid = 1'b0;
        bus.ofm_data  = '0;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int rd0;
        logic [63:0] d0;
        logic stable;

        bus.start = 1'b0; bus.flt_ready = 1'b0; bus.ifm_ready = 1'b0;
        bus.ofm_valid = 1'b0; bus.ofm_data = '0;
        repeat (3) @(negedge clk);
        chkEq("rst_status", 64'({bus.busy, bus.done, bus.err, bus.ofm_ready}), 64'd0);
        chkEq("rst_valids", 64'({bus.flt_valid, bus.ifm_valid, bus.mem_rd_en, bus.mem_wr_en}), 64'd0);
        chkEq("rst_data", bus.flt_data | bus.ifm_data, 64'd0);

        rst = 1'b0;
        bus.flt_ready = 1'b1;
        bus.ifm_ready = 1'b1;
        @(negedge clk);
        pulseStart();
        chkEq("first_rd", 64'({bus.mem_rd_en, bus.mem_rd_sel, bus.mem_row, bus.mem_col}), 64'({1'b1, 1'b0, 8'd0, 8'd0}));
        cyc = 0;
        while (!bus.flt_valid && cyc < 40) begin @(negedge clk); cyc++; end
        chkEq("flt0_latency", 64'(cyc), 64'd7);
        chkEq("flt0_data", bus.flt_data, 64'h0040_0005_0403_0201);

        @(negedge clk);
        bus.flt_ready = 1'b0;
        cyc = 0;
        while (!bus.flt_valid && cyc < 40) begin @(negedge clk); cyc++; end
        chkEq("flt1_valid", 64'(bus.flt_valid), 64'd1);
        rd0 = fltReads;
        d0 = bus.flt_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.flt_data !== d0 || !bus.flt_valid) stable = 1'b0;
        end
        chkEq("flt1_stable", 64'(stable), 64'd1);
        chkEq("flt1_no_reads", 64'(fltReads - rd0), 64'd0);
        chkEq("flt1_reads", 64'(rd0), 64'd10);
        chkEq("flt1_data", d0, 64'h0140_000A_0908_0706);
        bus.flt_ready = 1'b1;

        chkEq("err_clean", 64'(bus.err), 64'd0);
        sendOfm(OUT_HDR | 64'h087);
        chkEq("wr_4_7", 64'({bus.mem_wr_en, bus.mem_wr_t, bus.mem_wr_row, bus.mem_wr_col}), 64'({1'b1, 8'd0, 8'd4, 8'd7}));
        sendOfm(OUT_HDR | 64'h2A0);
        chkEq("row21_no_wr", 64'(bus.mem_wr_en), 64'd0);
        chkEq("row21_err", 64'(bus.err), 64'd1);
        sendOfm(64'h0000_0000_0000_0087);
        chkEq("type00_drop", 64'(bus.mem_wr_en), 64'd0);
        repeat (3) sendOfm(OUT_HDR | 64'h1FF);
        chkEq("done_no_wr", 64'(bus.mem_wr_en), 64'd0);

        cyc = 0;
        while (ifmPkts < 25 && cyc < 2000) begin @(negedge clk); cyc++; end
        chkEq("ifm_cnt_t0", 64'(ifmPkts), 64'd25);
        chkEq("ifm_r3", ifmLog[3], 64'h0300_0000_0100_0001);
        chkEq("ifm_r0", ifmLog[0], ifmPkt(0, 0, 4'h0));
        chkEq("ifm_r4", ifmLog[4], ifmPkt(0, 4, 4'h9));
        chkEq("ifm_r5", ifmLog[5], ifmPkt(0, 5, 4'h0));

        repeat (3) sendOfm(OUT_HDR | 64'h1FF);
        repeat (3) @(negedge clk);
        chkEq("six_dones_wait", 64'({bus.mem_rd_en, bus.busy}), 64'({1'b0, 1'b1}));
        sendOfm(OUT_HDR | 64'h1FF);
        cyc = 0;
        while (!bus.mem_rd_en && cyc < 10) begin @(negedge clk); cyc++; end
        chkEq("t1_ifm_rd", 64'({bus.mem_rd_en, bus.mem_rd_sel, bus.mem_t, bus.mem_row, bus.mem_col}),
              64'({1'b1, 1'b1, 8'd1, 8'd0, 8'd0}));
        chkEq("t1_no_flt", 64'({fltReads[7:0], fltPkts[7:0]}), 64'({8'd25, 8'd5}));

        sendOfm(OUT_HDR | 64'h294);
        chkEq("wr_20_20_t1", 64'({bus.mem_wr_en, bus.mem_wr_t, bus.mem_wr_row, bus.mem_wr_col}), 64'({1'b1, 8'd1, 8'd20, 8'd20}));
        sendOfm(OUT_HDR | 64'h015);
        chkEq("col21_no_wr", 64'(bus.mem_wr_en), 64'd0);

        cyc = 0;
        while (ifmPkts < 50 && cyc < 2000) begin @(negedge clk); cyc++; end
        chkEq("ifm_cnt_t1", 64'(ifmPkts), 64'd50);
        chkEq("ifm_t1_r1", ifmLog[26], ifmPkt(1, 1, 4'h1));
        repeat (7) sendOfm(OUT_HDR | 64'h1FF);
        cyc = 0;
        while (!bus.done && cyc < 10) begin @(negedge clk); cyc++; end
        chkEq("finish", 64'({bus.done, bus.busy, bus.ofm_ready}), 64'({1'b1, 1'b0, 1'b0}));
        pulseStart();
        @(negedge clk);
        chkEq("finish_hold", 64'({bus.done, bus.busy, bus.mem_rd_en}), 64'({1'b1, 1'b0, 1'b0}));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chkEq("rst2_clear", 64'({bus.done, bus.err, bus.busy}), 64'd0);
        bus.ifm_ready = 1'b0;
        pulseStart();
        cyc = 0;
        while (!bus.ifm_valid && cyc < 400) begin @(negedge clk); cyc++; end
        chkEq("ifm_send_reach", 64'(bus.ifm_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chkEq("rst_in_send", 64'({bus.ifm_valid, bus.busy, bus.mem_wr_en, bus.mem_rd_en}), 64'd0);
        pulseStart();
        chkEq("restart_rd", 64'({bus.mem_rd_en, bus.mem_rd_sel, bus.mem_row, bus.mem_col}), 64'({1'b1, 1'b0, 8'd0, 8'd0}));
        cyc = 0;
        while (!bus.flt_valid && cyc < 40) begin @(negedge clk); cyc++; end
        chkEq("restart_flt0", bus.flt_data, 64'h0040_0005_0403_0201);

        $display("TB_RESULT checks=%0d failures=%0d", nChk, nFail);
        $finish;
    end
endmodule

// File: doc/noc_mem_packetizer.md
NOC_MEM_PACKETIZER -- requirements
Module: noc_mem_packetizer

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
 NUM_PE 5, destination PE count; FILT_ROWS 5, FILT_COLS 5, filter shape; WEIGHT_W 8, weight width.
 IFM_ROWS 25, IFM_COLS 25, ifmap shape; OFM_ROWS 21, OFM_COLS 21, ofmap shape; TIMESTEPS 10, timestep count.
 NOC_W 64, packet width; DONES_PER_T 7, done packets closing one timestep; RELOAD_FILT 0, 1 = resend filters every timestep.
 SRC_ADDR 4'h0, own node address; PE_ADDR {4'h9,4'h3,4'h2,4'h1,4'h0}, NUM_PE x 4-bit destination table.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
 clk in 1, single clock; rst in 1, reset, synchronous, active-high.
 start in 1, one-cycle pulse that begins a run; busy out 1, run in progress; done out 1, run complete (sticky); err out 1, sticky out-of-range flag.
 mem_rd_en out 1; mem_rd_sel out 1 (0 filter, 1 ifmap); mem_t/mem_row/mem_col out 8 each; mem_rd_data in max(WEIGHT_W,1), valid one cycle after mem_rd_en.
 mem_wr_en out 1; mem_wr_t/mem_wr_row/mem_wr_col out 8 each, ofmap bit-set write.
 flt_valid out 1, flt_ready in 1, flt_data out NOC_W, filter packet port.
 ifm_valid out 1, ifm_ready in 1, ifm_data out NOC_W, ifmap packet port.
 ofm_valid in 1, ofm_ready out 1, ofm_data in NOC_W, returning output packets.

Function
REQ-003 Packet format SHALL be [NOC_W-1:NOC_W-4] source, [NOC_W-5:NOC_W-8] destination, [NOC_W-9:NOC_W-10] type (00 ifmap, 01 kernel, 11 output), zero-filled middle, payload right-aligned at bit 0.
REQ-004 FSM states SHALL be IDLE, FLT_RD, FLT_SEND, IFM_RD, IFM_SEND, WAIT_DONE, FINISH; start is ignored outside IDLE.
REQ-005 FLT_RD SHALL issue FILT_COLS reads (col 0 first, one per cycle) for filter row r, packing col c into payload bits [c*WEIGHT_W +: WEIGHT_W].
REQ-006 FLT_SEND SHALL present a kernel packet to PE_ADDR[r mod NUM_PE]; after handshake, r increments; after FILT_ROWS rows go to IFM_RD.
REQ-007 IFM_RD SHALL read IFM_COLS bits of ifmap row r at timestep t, col c into payload bit c; IFM_SEND SHALL send type-00 packet to PE_ADDR[r mod NUM_PE]; after IFM_ROWS rows go to WAIT_DONE.
REQ-008 A valid output SHALL hold its data stable until ready; transfer occurs on the cycle where valid and ready are both high.
REQ-009 ofm_ready SHALL be 1 in every state except IDLE and FINISH; accepted packets with type != 11 are dropped.
REQ-010 Type-11 packets with payload[9:0] != 10'h1FF SHALL produce mem_wr_en the next cycle at (t, payload[9:5], payload[4:0]); row >= OFM_ROWS or col >= OFM_COLS SHALL suppress the write and set err.
REQ-011 Type-11 packets with payload[9:0] == 10'h1FF SHALL increment done_cnt without any write; done packets arriving before WAIT_DONE SHALL still be counted.
REQ-012 When done_cnt reaches DONES_PER_T in WAIT_DONE: done_cnt clears, t increments; if t == TIMESTEPS go to FINISH, otherwise go to FLT_RD if RELOAD_FILT else IFM_RD.
REQ-013 FINISH SHALL assert done and deassert busy and remain there until rst.
REQ-014 Payload widths exceeding NOC_W-10 SHALL be a compile-time error.

Reset
REQ-015 On rst, all outputs SHALL be 0 the next edge, with state IDLE and all counters (r, c, t, done_cnt) zero.
REQ-016 rst mid-transfer SHALL drop valid without completing the packet; no memory write occurs in the reset cycle.

Structure
REQ-017 Packet type codes, field offsets, DONE_MARK 10'h1FF and the FSM state enum SHALL live in shared package snn_noc_pkg.
REQ-018 Row packing SHALL be a sub-module row_packer (column counter, shift/insert register, full flag), instantiated once and reused by the filter and ifmap phases.

Verification
REQ-019 Filter row 0 = weights 1..5, flt_ready=1 -> flt_data = {4'h0,4'h0,2'b01,0...,40'h0504030201}, 7 cycles after start.
REQ-020 flt_ready held low 10 cycles during FLT_SEND -> flt_data stable, no extra memory reads issued.
REQ-021 Ifmap t=0 row 3 = bit pattern 25'h1000001 -> type-00 packet to 4'h3 with payload 25'h1000001.
REQ-022 ofm packet type 11, payload row 4, col 7 -> mem_wr_en at (0,4,7); row 21 -> no write, err=1.
REQ-023 Seven done packets with TIMESTEPS=2, RELOAD_FILT=0 -> t=1, state IFM_RD with no filter resend; seven more -> done=1.
REQ-024 rst asserted in IFM_SEND -> next cycle ifm_valid=0, busy=0; a subsequent start restarts at filter row 0.
